// File: rtl/command_decoder.sv
// rtl/command_decoder.sv - byte FIFO plus parser that frames SPI bytes into rasteriser commands
//
// Purpose:
//   Buffers the SPI receiver byte stream in a small FIFO and frames it into
//   commands of one opcode byte followed by 0..7 payload bytes. Each framed
//   command is presented to the executor on a valid/ready handshake.
//
// Ports:
//   clk             system clock
//   rst             asynchronous active-low reset, released synchronously to clk
//   command_wrdata  byte from the SPI receiver, qualified by command_push
//   command_push    single-cycle byte strobe
//   cmd_opcode      opcode of the presented command (opcode byte [7:3])
//   cmd_len         payload byte count of the presented command (opcode byte [2:0])
//   cmd_payload     payload, byte k at [8k+7:8k], unused bytes are zero
//   cmd_valid       a framed command is being presented
//   cmd_ready       executor accepts the presented command
//   fifo_level      FIFO occupancy, 0..FIFO_DEPTH
//   overflow        sticky: a byte was dropped because the FIFO was full

module command_decoder #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         command_wrdata,
  input  logic               command_push,
  output logic [4:0]         cmd_opcode,
  output logic [2:0]         cmd_len,
  output logic [55:0]        cmd_payload,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_e;

  localparam logic [FIFO_AW:0]   LEVEL_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0]   LEVEL_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE    = {{(FIFO_AW - 1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               overflow_q, overflow_d;

  logic               fifo_full;
  logic               fifo_pop;
  logic               fifo_wr;
  logic [7:0]         head_byte;

  // ---------------------------------------------------------------------------
  // Parser state
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [4:0]  opcode_q, opcode_d;
  logic [2:0]  len_q, len_d;
  logic [55:0] payload_q, payload_d;
  logic [2:0]  index_q, index_d;

  assign head_byte = mem_q[rd_ptr_q];
  assign fifo_full = (level_q == LEVEL_FULL);

  // The parser only consumes bytes while it is collecting a command; in
  // OUTPUT the FIFO just fills up behind the pending command. Because the
  // level is registered, a byte written at this edge is never visible to
  // the pop decision of the same edge.
  assign fifo_pop = (level_q != '0) &&
                    ((state_q == ST_IDLE) || (state_q == ST_PAYLOAD));

  // A full FIFO still accepts a byte when the head leaves at the same edge;
  // the freed slot is the one the write pointer already points at.
  assign fifo_wr = command_push && (!fifo_full || fifo_pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (fifo_wr) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({fifo_wr, fifo_pop})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase

    if (command_push && !fifo_wr) begin
      overflow_d = 1'b1;
    end
  end

  // Storage needs no reset: the level decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_q[wr_ptr_q] <= command_wrdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Parser FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      opcode_q  <= '0;
      len_q     <= '0;
      payload_q <= '0;
      index_q   <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      len_q     <= len_d;
      payload_q <= payload_d;
      index_q   <= index_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Parser FSM: next state and command registers
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    len_d     = len_q;
    payload_d = payload_q;
    index_d   = index_q;

    case (state_q)
      ST_IDLE: begin
        if (fifo_pop) begin
          opcode_d  = head_byte[7:3];
          len_d     = head_byte[2:0];
          payload_d = '0;
          index_d   = '0;
          if (head_byte == 8'h00) begin
            // NOP: consumed, nothing is framed
            state_d = ST_IDLE;
          end else if (head_byte[2:0] == 3'd0) begin
            state_d = ST_OUTPUT;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (fifo_pop) begin
          payload_d[{index_q, 3'b000} +: 8] = head_byte;
          index_d = index_q + 3'd1;
          // len_q is at least 1 here, so len_q-1 does not underflow
          if (index_q == (len_q - 3'd1)) begin
            state_d = ST_OUTPUT;
          end
        end
      end

      ST_OUTPUT: begin
        if (cmd_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Parser FSM: outputs, all taken straight from registers
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_valid   = (state_q == ST_OUTPUT);
    cmd_opcode  = opcode_q;
    cmd_len     = len_q;
    cmd_payload = payload_q;
    fifo_level  = level_q;
    overflow    = overflow_q;
  end

endmodule

// File: tb/tb_command_decoder.sv
// tb/tb_command_decoder.sv - directed self-checking bench for command_decoder

module tb_command_decoder;

  logic        clk;
  logic        rst;
  logic [7:0]  command_wrdata;
  logic        command_push;
  logic [4:0]  cmd_opcode;
  logic [2:0]  cmd_len;
  logic [55:0] cmd_payload;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  fifo_level;
  logic        overflow;

  int vectors;
  int miscompares;

  command_decoder #(
    .FIFO_DEPTH (16),
    .FIFO_AW    (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .command_wrdata (command_wrdata),
    .command_push   (command_push),
    .cmd_opcode     (cmd_opcode),
    .cmd_len        (cmd_len),
    .cmd_payload    (cmd_payload),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .fifo_level     (fifo_level),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    command_wrdata = b;
    command_push   = 1'b1;
    tick();
    command_push   = 1'b0;
    command_wrdata = 8'h00;
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst            = 1'b0;
    command_wrdata = 8'h00;
    command_push   = 1'b0;
    cmd_ready      = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_valid",    cmd_valid,   0);
    check("rst_opcode",   cmd_opcode,  0);
    check("rst_len",      cmd_len,     0);
    check("rst_payload",  cmd_payload, 0);
    check("rst_level",    fifo_level,  0);
    check("rst_overflow", overflow,    0);
    rst = 1'b1;
    tick();

    // Three-byte payload command, executor always ready
    cmd_ready = 1'b1;
    command_wrdata = 8'h0B; command_push = 1'b1; tick();   // E0
    check("t1_level_e0", fifo_level, 1);
    check("t1_valid_e0", cmd_valid, 0);
    command_wrdata = 8'h11; tick();                        // E1
    command_wrdata = 8'h22; tick();                        // E2
    command_wrdata = 8'h33; tick();                        // E3
    command_push = 1'b0;
    check("t1_valid_e3", cmd_valid, 0);
    check("t1_level_e3", fifo_level, 1);
    tick();                                                // E4
    check("t1_valid_e4",   cmd_valid,   1);
    check("t1_opcode",     cmd_opcode,  5'h01);
    check("t1_len",        cmd_len,     3);
    check("t1_payload",    cmd_payload, 56'h00000000332211);
    check("t1_level_e4",   fifo_level,  0);
    tick();                                                // E5
    check("t1_valid_e5",   cmd_valid,   0);

    // NOP followed by a len-0 command
    command_wrdata = 8'h00; command_push = 1'b1; tick();   // A0
    command_wrdata = 8'h08; tick();                        // A1: NOP consumed
    command_push = 1'b0;
    check("t2_nop_valid", cmd_valid, 0);
    tick();                                                // A2
    check("t2_valid",   cmd_valid,   1);
    check("t2_opcode",  cmd_opcode,  5'h01);
    check("t2_len",     cmd_len,     0);
    check("t2_payload", cmd_payload, 0);
    tick();
    check("t2_valid_drop", cmd_valid, 0);

    // Back-pressure: outputs held, then a bubble before the next command
    cmd_ready = 1'b0;
    push_byte(8'h09);
    push_byte(8'hAA);
    push_byte(8'h10);
    check("t3_valid",   cmd_valid,   1);
    check("t3_opcode",  cmd_opcode,  5'h01);
    check("t3_len",     cmd_len,     1);
    check("t3_payload", cmd_payload, 56'hAA);
    check("t3_level",   fifo_level,  1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_valid",   cmd_valid,   1);
      check("t3_hold_opcode",  cmd_opcode,  5'h01);
      check("t3_hold_payload", cmd_payload, 56'hAA);
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("t3_bubble_valid", cmd_valid,  0);
    check("t3_bubble_level", fifo_level, 1);
    tick();
    check("t3_next_valid",   cmd_valid,   1);
    check("t3_next_opcode",  cmd_opcode,  5'h02);
    check("t3_next_len",     cmd_len,     0);
    check("t3_next_payload", cmd_payload, 0);
    check("t3_next_level",   fifo_level,  0);

    // Overflow while a command is pending (opcode 0x02 held)
    for (int k = 0; k < 16; k++) begin
      push_byte(8'((k + 3) << 3));
    end
    check("t4_level_16",   fifo_level, 16);
    check("t4_ovf_before", overflow,   0);
    push_byte(8'((16 + 3) << 3));
    check("t4_level_17",   fifo_level, 16);
    check("t4_ovf_after",  overflow,   1);
    cmd_ready = 1'b1;
    tick();                                                // opcode 0x02 accepted
    check("t4_drain_start", cmd_valid, 0);
    for (int k = 0; k < 16; k++) begin
      tick();
      check("t4_drain_valid",  cmd_valid,  1);
      check("t4_drain_opcode", cmd_opcode, 64'(k + 3));
      tick();
      check("t4_drain_bubble", cmd_valid, 0);
    end
    tick();
    tick();
    check("t4_no_dropped_cmd", cmd_valid,  0);
    check("t4_level_empty",    fifo_level, 0);
    check("t4_ovf_sticky",     overflow,   1);

    // Full FIFO with simultaneous pop and push
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("t5_ovf_cleared", overflow, 0);
    cmd_ready = 1'b0;
    push_byte(8'h08);
    tick();
    check("t5_pending", cmd_valid, 1);
    for (int k = 0; k < 16; k++) begin
      push_byte(8'h10);
    end
    check("t5_level_full", fifo_level, 16);
    cmd_ready = 1'b1;
    tick();                                                // back to IDLE, no pop yet
    cmd_ready = 1'b0;
    check("t5_idle_level", fifo_level, 16);
    push_byte(8'h18);                                      // pop and push together
    check("t5_level_kept", fifo_level, 16);
    check("t5_ovf_clear",  overflow,   0);
    check("t5_valid",      cmd_valid,  1);
    check("t5_opcode",     cmd_opcode, 5'h02);

    // Asynchronous reset in the middle of a payload
    rst = 1'b0;
    tick();
    rst = 1'b1;
    cmd_ready = 1'b1;
    push_byte(8'h0B);
    push_byte(8'h11);
    tick();                                                // 0x11 stored in payload
    check("t6_pre_len",     cmd_len,     3);
    check("t6_pre_payload", cmd_payload, 56'h11);
    #3;
    rst = 1'b0;
    #1;
    check("t6_async_opcode",  cmd_opcode,  0);
    check("t6_async_len",     cmd_len,     0);
    check("t6_async_payload", cmd_payload, 0);
    check("t6_async_valid",   cmd_valid,   0);
    check("t6_async_level",   fifo_level,  0);
    check("t6_async_ovf",     overflow,    0);
    tick();
    rst = 1'b1;
    push_byte(8'h08);
    check("t6_post_valid_e0", cmd_valid, 0);
    tick();
    check("t6_post_valid",   cmd_valid,   1);
    check("t6_post_opcode",  cmd_opcode,  5'h01);
    check("t6_post_len",     cmd_len,     0);
    check("t6_post_payload", cmd_payload, 0);
    tick();
    check("t6_post_drop", cmd_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
